// File: rtl/trace_uart_tx.sv
// trace_uart_tx: queues rv32i commit events and serialises each one as a UART 8N1 byte frame.
// Define TRACE_MEM_EN to also capture data-memory writes (addr/wr_data); otherwise only register writebacks.
module trace_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_sig,
  input  logic [4:0]        reg_num,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr,
  input  logic [8:0]        addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow
);
  // state | meaning
  // IDLE  | line high, pop next entry when the FIFO is non-empty
  // START | start bit (0) for one bit time
  // DATA  | data bits of the current byte, LSB first
  // STOP  | stop bit (1), then next byte or back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int DB          = (DATA_W + 7) / 8;
  localparam int DPAD        = 8 * DB;
  localparam int FRAME_BYTES = 3 + 2 * DB;
  localparam int FRAME_W     = 8 * FRAME_BYTES;
  localparam int BI_W        = $clog2(FRAME_BYTES);
  localparam int BAUD_W      = $clog2(CLKS_PER_BIT);

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BI_W-1:0]   BI_ONE    = BI_W'(1);

  logic reg_ev, mem_ev, push, pop;
  logic [7:0] hdr_in;

  assign reg_ev = reg_write_sig && (reg_num != 5'd0);
`ifdef TRACE_MEM_EN
  assign mem_ev = wr;
`else
  assign mem_ev = 1'b0;
  logic unused_mem;
  assign unused_mem = ^{wr, addr, wr_data};
`endif
  assign hdr_in = {reg_ev, mem_ev, 1'b0, reg_ev ? reg_num : 5'd0};
  // Drop decision uses the registered full flag, so a same-cycle pop never rescues an event.
  assign push = (reg_ev || mem_ev) && !fifo_full;

  logic [7:0]        hdr_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] rdat_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_ptr]  <= hdr_in;
      rdat_mem[wr_ptr] <= reg_data;
    end
  end

`ifdef TRACE_MEM_EN
  logic [8:0]        addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] wdat_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= addr;
      wdat_mem[wr_ptr] <= wr_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      if ((reg_ev || mem_ev) && fifo_full) overflow <= 1'b1;
    end
  end

  assign fifo_full = (count == CNT_FULL);

  // Frame image assembled at pop time, header in the low byte; the byte on the wire is always frame_q[7:0].
  logic [7:0]         rd_hdr;
  logic [DPAD-1:0]    rd_ext;
  logic [FRAME_W-1:0] frame_in;
  logic [BI_W-1:0]    last_in;

  assign rd_hdr = hdr_mem[rd_ptr];

  always_comb begin
    rd_ext = '0;
    rd_ext[DATA_W-1:0] = rdat_mem[rd_ptr];
  end

`ifdef TRACE_MEM_EN
  logic [DPAD-1:0] wd_ext;
  logic [15:0]     addr16;

  always_comb begin
    wd_ext = '0;
    wd_ext[DATA_W-1:0] = wdat_mem[rd_ptr];
  end
  assign addr16 = {7'b0, addr_mem[rd_ptr]};

  always_comb begin
    if (rd_hdr[7]) frame_in = {wd_ext, addr16, rd_ext, rd_hdr};
    else           frame_in = {{DPAD{1'b0}}, wd_ext, addr16, rd_hdr};
  end
`else
  assign frame_in = {{(DPAD + 16){1'b0}}, rd_ext, rd_hdr};
`endif

  assign last_in = BI_W'((rd_hdr[7] ? DB : 0) + (rd_hdr[6] ? DB + 2 : 0));

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [BI_W-1:0]    byte_q, byte_d, last_q;
  logic [FRAME_W-1:0] frame_q;
  logic               tx_q, tx_d, load, shift, baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          load    = 1'b1;
          byte_d  = '0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q == last_q) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + BI_ONE;
            shift   = 1'b1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is computed from the next state so the flop output lines up with the state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = frame_q[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      last_q  <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      if (load) begin
        frame_q <= frame_in;
        last_q  <= last_in;
      end else if (shift) begin
        frame_q <= frame_q >> 8;
      end
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (count != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for trace_uart_tx: a UART receiver model decodes frames and compares against hand-computed bytes.
module tb_trace_uart_tx;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_write_sig = 1'b0;
  logic [4:0]  reg_num = '0;
  logic [31:0] reg_data = '0;
  logic        wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic        uart_tx, busy, fifo_full, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_start = 0;
  int t_idle;
  logic [7:0] exp_q[$];

  trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .addr(addr), .wr_data(wr_data),
    .uart_tx(uart_tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ev(input logic rws, input logic [4:0] rn, input logic [31:0] rd,
                          input logic w, input logic [8:0] a, input logic [31:0] wd);
    reg_write_sig = rws; reg_num = rn; reg_data = rd;
    wr = w; addr = a; wr_data = wd;
    @(negedge clk);
    reg_write_sig = 1'b0; wr = 1'b0;
  endtask

  // Detects the start bit, then samples the middle of each bit time.
  task automatic rx_byte(input string tag, output logic [7:0] b, output bit ok, output int t);
    int n = 0;
    b = '0; ok = 1'b1; t = cyc;
    while (uart_tx !== 1'b0) begin
      if (n == 400) begin ok = 1'b0; return; end
      @(negedge clk); n++;
    end
    t = cyc;
    repeat (2) @(negedge clk);
    chk({tag, " start bit"}, uart_tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    chk({tag, " stop bit"}, uart_tx, 1'b1);
  endtask

  task automatic rx_frame(input string tag);
    logic [7:0] b;
    bit ok;
    int t;
    foreach (exp_q[i]) begin
      rx_byte(tag, b, ok, t);
      if (i == 0) frame_start = t;
      chk($sformatf("%s byte%0d timeout", tag, i), ok, 1'b1);
      if (!ok) return;
      chk($sformatf("%s byte%0d", tag, i), b, exp_q[i]);
    end
  endtask

  task automatic wait_idle(input string tag, output int c);
    int n = 0;
    while (busy !== 1'b0 && n < 600) begin @(negedge clk); n++; end
    chk({tag, " idle timeout"}, busy, 1'b0);
    c = cyc;
  endtask

  task automatic quiet(input string tag, input int n);
    bit low = 1'b0;
    bit bsy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low = 1'b1;
      if (busy !== 1'b0) bsy = 1'b1;
    end
    chk({tag, " tx went low"}, low, 1'b0);
    chk({tag, " busy seen"}, bsy, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset uart_tx", uart_tx, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset fifo_full", fifo_full, 1'b0);
    chk("reset overflow", overflow, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single register write: tx falls two cycles after the event, frame is 200 cycles.
    drive_ev(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 9'h0, 32'h0);
    chk("reg lat cycle1 tx", uart_tx, 1'b1);
    chk("reg lat cycle1 busy", busy, 1'b1);
    @(negedge clk);
    chk("reg lat cycle2 tx", uart_tx, 1'b0);
    exp_q = {8'h85, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rx_frame("reg");
    wait_idle("reg", t_idle);
    chk("reg frame length", t_idle - frame_start, 200);
    repeat (3) @(negedge clk);

    // Write to x0 never produces an entry.
    drive_ev(1'b1, 5'd0, 32'h12345678, 1'b0, 9'h0, 32'h0);
    quiet("x0", 30);

    // Memory write.
    drive_ev(1'b0, 5'd9, 32'hFFFFFFFF, 1'b1, 9'h104, 32'h12345678);
`ifdef TRACE_MEM_EN
    exp_q = {8'h40, 8'h04, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    rx_frame("mem");
    wait_idle("mem", t_idle);
    chk("mem frame length", t_idle - frame_start, 280);
`else
    quiet("mem disabled", 100);
`endif
    repeat (3) @(negedge clk);

    // Combined register + memory event in one cycle.
    drive_ev(1'b1, 5'd1, 32'h00000001, 1'b1, 9'h008, 32'h000000AA);
`ifdef TRACE_MEM_EN
    exp_q = {8'hC1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00};
`else
    exp_q = {8'h81, 8'h01, 8'h00, 8'h00, 8'h00};
`endif
    rx_frame("comb");
    wait_idle("comb", t_idle);
    repeat (3) @(negedge clk);

    // Overflow: six back-to-back events, the sixth is dropped.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 4) chk("ovf full before ev5", fifo_full, 1'b0);
          if (i == 5) begin
            chk("ovf full before ev6", fifo_full, 1'b1);
            chk("ovf flag before ev6", overflow, 1'b0);
          end
          reg_write_sig = 1'b1;
          reg_num = 5'(i + 1);
          reg_data = 32'hA0B0C0D0 + 32'(i);
          @(negedge clk);
        end
        reg_write_sig = 1'b0;
        chk("ovf flag after ev6", overflow, 1'b1);
      end
      begin
        for (int f = 0; f < 5; f++) begin
          exp_q = {8'(8'h80 + f + 1), 8'(8'hD0 + f), 8'hC0, 8'hB0, 8'hA0};
          rx_frame($sformatf("ovf frame%0d", f));
        end
      end
    join
    wait_idle("ovf", t_idle);
    chk("ovf fifo_full drained", fifo_full, 1'b0);
    chk("ovf sticky", overflow, 1'b1);
    quiet("ovf no sixth frame", 60);

    // Reset in byte 2, bit 3, with a second entry still queued.
    drive_ev(1'b1, 5'd3, 32'h11223344, 1'b0, 9'h0, 32'h0);
    drive_ev(1'b1, 5'd4, 32'h55667788, 1'b0, 9'h0, 32'h0);
    chk("rst frame start", uart_tx, 1'b0);
    repeat (97) @(negedge clk);
    chk("rst byte2 bit3 level", uart_tx, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst uart_tx", uart_tx, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst fifo_full", fifo_full, 1'b0);
    chk("rst overflow", overflow, 1'b0);
    reset = 1'b0;
    quiet("rst queue lost", 60);

    drive_ev(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 9'h0, 32'h0);
    exp_q = {8'h87, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    rx_frame("post rst");
    wait_idle("post rst", t_idle);
    chk("post rst frame length", t_idle - frame_start, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_uart_tx.md
# trace_uart_tx

Commit-trace transmitter for the rv32i core. Listens to the core's register-writeback and data-memory-write outputs, queues each retired event in a FIFO, and serialises it as a byte frame on a UART 8N1 line. The core's trace ports are the writer; this block is the reader that exports them off-chip for lab debugging. It sits beside `riscv` at board top and never stalls the core.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- `FIFO_DEPTH`, default 16: number of event entries; must be a power of 2, 2 or more.
- `DATA_W`, default 32: data width of the trace data.
- `clk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `reg_write_sig` in 1: register write strobe from the core.
- `reg_num` in 5: destination register number.
- `reg_data` in DATA_W: value written to the register.
- `wr` in 1: data-memory write strobe.
- `addr` in 9: data-memory address.
- `wr_data` in DATA_W: data-memory write data.
- `uart_tx` out 1: serial line, idle high.
- `busy` out 1: high when the FIFO is non-empty or the FSM is not in IDLE.
- `fifo_full` out 1: FIFO count equals FIFO_DEPTH.
- `overflow` out 1: sticky; set when an event is dropped, cleared only by reset.

## Operation
- **Capture (every cycle)**
  - reg_ev = reg_write_sig && reg_num != 0.
  - mem_ev = wr.
  - If reg_ev or mem_ev, push one entry {reg_ev, mem_ev, reg_num, reg_data, addr, wr_data}.
  - A cycle with both events produces one combined entry.
- **Drop rule**
  - If fifo_full at the start of the cycle, the event is dropped and overflow is set. This holds even if a pop occurs in the same cycle.
- **Frame format**, bytes LSB first:
  - Header = {reg_ev, mem_ev, 1'b0, reg_num}. reg_num is forced to 0 when reg_ev = 0.
  - If reg_ev: 4 bytes of reg_data.
  - If mem_ev: 2 bytes of {7'b0, addr}, then 4 bytes of wr_data.
  - Frame lengths: 5 bytes (register only), 7 bytes (memory only), 11 bytes (both).
- **FSM states**
  - IDLE: if the FIFO is non-empty, pop the entry into the frame register, set byte_idx = 0, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx = 0.
  - DATA: drive bit bit_idx of the current byte for CLKS_PER_BIT cycles each; after bit 7 go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then, if the byte just sent was the last byte of the frame, go to IDLE; otherwise increment byte_idx and go to START.
- **Counters**
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps.
  - FIFO read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
- **Reset values**
  - uart_tx = 1, busy = 0, fifo_full = 0, overflow = 0.
  - FIFO emptied, FSM in IDLE, all counters 0.
- **Reset mid-frame**
  - uart_tx is 1 in the cycle after the reset edge.
  - The partial frame is abandoned and queued entries are lost.

## Timing
- An event present in cycle N is written at the edge ending cycle N and is visible to IDLE in cycle N+1.
- Given an empty FIFO and IDLE, the pop occurs at the edge ending N+1 and uart_tx is 0 from cycle N+2.
- Each byte occupies exactly 10 × CLKS_PER_BIT cycles. Bytes within a frame are back-to-back with no gap.
- Between frames there is at least 1 idle-high cycle (the IDLE pop cycle).
- uart_tx is driven directly from a flop, so there are no glitches.
- fifo_full and busy are registered and reflect state after the most recent edge.

## Configuration
- `TRACE_MEM_EN` defined: memory-write capture works as described above.
- `TRACE_MEM_EN` undefined:
  - mem_ev is tied to 0; wr, addr and wr_data are ignored (ports remain).
  - Header bit 6 is always 0, and only 5-byte frames are emitted.
  - The addr and wr_data fields are not stored in the FIFO.

## Test plan
Use CLKS_PER_BIT = 4 (40 cycles per byte) and FIFO_DEPTH = 4, with TRACE_MEM_EN defined unless noted. All waveforms are checked against a UART receiver model.
- **Single register write:** one cycle with reg_write_sig = 1, reg_num = 5, reg_data = 0xDEADBEEF -> bytes 0x85, EF, BE, AD, DE; uart_tx falls 2 cycles after the event; frame lasts 200 cycles; busy then drops.
- **Write to x0:** reg_write_sig = 1, reg_num = 0 -> no FIFO push, uart_tx stays 1, busy stays 0.
- **Memory write:** wr = 1, addr = 0x104, wr_data = 0x12345678 -> bytes 0x40, 04, 01, 78, 56, 34, 12. Repeated with TRACE_MEM_EN undefined -> no frame.
- **Combined event:** reg_num = 1, reg_data = 0x1, wr = 1, addr = 0x008, wr_data = 0xAA in the same cycle -> bytes 0xC1, 01, 00, 00, 00, 08, 00, AA, 00, 00, 00.
- **Overflow:** 6 consecutive register-write cycles -> fifo_full asserts, the 6th event is dropped, overflow = 1, and exactly 5 frames are transmitted in order.
- **Reset mid-frame:** reset asserted at byte 2, bit 3 -> uart_tx = 1 in the next cycle, FIFO empty, busy = 0, overflow = 0; a new event afterwards yields a complete, correct frame.
